// File: rtl/counter_trig_decoder_pkg.sv
// Shared types and helpers for the trigger-bus count decoder.
// Pure declarations, no logic latency.
// Not applicable: no handshake, only a state enum and a pattern function.
package counter_trig_pkg;

  // Widest counter the pattern helper supports; callers cast down to WIDTH.
  localparam int unsigned TRIG_MAX_W = 32;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Bits that fall 1->0 when a counter steps from m: the trailing ones of m.
  // Stepping from all-ones gives all-ones, because m+1 carries out of the top.
  function automatic logic [TRIG_MAX_W-1:0] exp_trig(input logic [TRIG_MAX_W-1:0] m);
    return m & ~(m + TRIG_MAX_W'(1));
  endfunction

endpackage

// File: rtl/counter_trig_decoder_sat_counter.sv
// Saturating event counter with synchronous clear; clear is applied before increment.
// Latency: count reflects inc/clr one clock after the sampling edge.
// No backpressure: an increment at all-ones is silently absorbed.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] base;

  // Clear first so a simultaneous clear and event leaves exactly one count.
  always_comb begin
    base = clr ? '0 : cnt;
  end

  // Increment from the (possibly cleared) base, stopping at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (base != '1)) begin
      cnt <= base + WIDTH'(1);
    end else begin
      cnt <= base;
    end
  end

endmodule

// File: rtl/counter_trig_decoder.sv
// Rebuilds a remote counter's value from its per-bit falling-edge triggers and checks every step.
// Latency: once locked, count trails the remote counter by exactly one clk; err pulses the cycle after a bad sample.
// No backpressure: a pure observer that samples trig_in/n_en every cycle.
module counter_trig_decoder
  import counter_trig_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     n_en,
  input  logic [WIDTH-1:0]         trig_in,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         count,
  output logic                     locked,
  output logic                     err,
  output logic                     err_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  state_t           state;
  logic             step_d;
  logic [WIDTH-1:0] exp_pat;
  logic             step_ok;
  logic             idle_ok;
  logic             sync_hit;
  logic             err_det;

  // Classify the current sample: good step, good idle, wrap sync, or a mismatch while locked.
  always_comb begin
    exp_pat  = WIDTH'(exp_trig(TRIG_MAX_W'(count)));
    step_ok  = step_d && (trig_in == exp_pat);
    idle_ok  = !step_d && (trig_in == '0);
    sync_hit = step_d && (trig_in == '1);
    err_det  = (state == LOCKED) && !(step_ok || idle_ok);
  end

  // Lock FSM, count reconstruction and error flags; step_d lines n_en up with the counter's registered triggers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      step_d     <= 1'b0;
      count      <= '0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      step_d     <= ~n_en;
      err        <= err_det;
      err_sticky <= err_det | (err_sticky & ~clr_err);
      case (state)
        SEARCH: begin
          // A wrap is the only sample that pins the count unambiguously.
          if (sync_hit) begin
            count <= '0;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (step_ok) begin
            count <= count + WIDTH'(1);
          end else if (err_det) begin
            state <= SEARCH;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  assign locked = (state == LOCKED);

  sat_counter #(
    .WIDTH(ERR_CNT_WIDTH)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_det),
    .clr (clr_err),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_counter_trig_decoder.sv
// Self-checking bench: behavioural counter drives two decoders (16-bit and 2-bit error counters).
// Expected outputs are queued per clock edge and checked by an independent monitor.
// No handshake on this block; every edge carries one expected result.
module tb_counter_trig_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        n_en = 1'b1;
  logic [3:0]  trig_in = 4'd0;
  logic        clr_err = 1'b0;

  logic [3:0]  a_count, b_count;
  logic        a_locked, b_locked, a_err, b_err, a_sticky, b_sticky;
  logic [15:0] a_ecnt;
  logic [1:0]  b_ecnt;

  counter_trig_decoder #(.WIDTH(4), .ERR_CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .n_en(n_en), .trig_in(trig_in), .clr_err(clr_err),
    .count(a_count), .locked(a_locked), .err(a_err), .err_sticky(a_sticky), .err_cnt(a_ecnt)
  );

  counter_trig_decoder #(.WIDTH(4), .ERR_CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .n_en(n_en), .trig_in(trig_in), .clr_err(clr_err),
    .count(b_count), .locked(b_locked), .err(b_err), .err_sticky(b_sticky), .err_cnt(b_ecnt)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          due;
    logic [3:0]  count;
    logic        locked;
    logic        err;
    logic        sticky;
    logic [15:0] ec16;
    logic [1:0]  ec2;
  } exp_t;
  exp_t q[$];

  // Reference state: the remote counter and the decoder's expected view of it.
  logic [3:0] cm = 4'd0;
  logic       m_locked = 1'b0;
  logic [3:0] m_count = 4'd0;
  logic       m_sticky = 1'b0;
  int         m_ec16 = 0;
  int         m_ec2 = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, want);
    end
  endtask

  // Bits that fall when stepping from m = the run of ones at the bottom of m.
  function automatic logic [3:0] falling_bits(input logic [3:0] m);
    int t = 0;
    while (t < 4 && m[t]) t++;
    return 4'((1 << t) - 1);
  endfunction

  // One clock: present n_en for the coming edge, then after it drive the counter's trig_out.
  task automatic cyc_step(input logic nen, input logic frc, input logic [3:0] ftrig, input logic clr);
    logic [3:0] t;
    logic       sd;
    logic       er;
    exp_t       e;
    n_en = nen;
    @(posedge clk);
    #1;
    if (!nen) begin
      t  = falling_bits(cm);
      cm = cm + 4'd1;
    end else begin
      t = 4'd0;
    end
    if (frc) t = ftrig;
    trig_in = t;
    clr_err = clr;
    sd = !nen;
    er = 1'b0;
    if (clr) begin
      m_sticky = 1'b0;
      m_ec16 = 0;
      m_ec2 = 0;
    end
    if (!m_locked) begin
      if (sd && t == 4'hF) begin
        m_locked = 1'b1;
        m_count = 4'd0;
      end
    end else if (sd && t == falling_bits(m_count)) begin
      m_count = m_count + 4'd1;
    end else if (!sd && t == 4'd0) begin
      m_count = m_count;
    end else begin
      er = 1'b1;
      m_sticky = 1'b1;
      if (m_ec16 < 65535) m_ec16++;
      if (m_ec2 < 3) m_ec2++;
      m_locked = 1'b0;
    end
    e.due = cyc + 1;
    e.count = m_count;
    e.locked = m_locked;
    e.err = er;
    e.sticky = m_sticky;
    e.ec16 = 16'(m_ec16);
    e.ec2 = 2'(m_ec2);
    q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"}, 32'(a_count), 0);
    check({tag, "_locked"}, 32'(a_locked), 0);
    check({tag, "_err"}, 32'(a_err), 0);
    check({tag, "_sticky"}, 32'(a_sticky), 0);
    check({tag, "_ecnt16"}, 32'(a_ecnt), 0);
    check({tag, "_ecnt2"}, 32'(b_ecnt), 0);
    check({tag, "_count2"}, 32'(b_count), 0);
  endtask

  task automatic do_reset(input int hold);
    q.delete();
    rst = 1'b1;
    n_en = 1'b1;
    trig_in = 4'd0;
    clr_err = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (hold) @(posedge clk);
    #1;
    check_zero("rst_hold");
    rst = 1'b0;
    m_locked = 1'b0;
    m_count = 4'd0;
    m_sticky = 1'b0;
    m_ec16 = 0;
    m_ec2 = 0;
  endtask

  task automatic run_until_locked();
    for (int i = 0; i < 40 && !m_locked; i++) cyc_step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic run_until_count(input logic [3:0] v);
    for (int i = 0; i < 60 && !(m_locked && m_count == v); i++) cyc_step(1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  // Monitor: compare both decoders against the expectation due at this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("count", 32'(a_count), 32'(e.count));
        check("locked", 32'(a_locked), 32'(e.locked));
        check("err", 32'(a_err), 32'(e.err));
        check("err_sticky", 32'(a_sticky), 32'(e.sticky));
        check("err_cnt16", 32'(a_ecnt), 32'(e.ec16));
        check("count_b", 32'(b_count), 32'(e.count));
        check("locked_b", 32'(b_locked), 32'(e.locked));
        check("err_b", 32'(b_err), 32'(e.err));
        check("err_cnt2", 32'(b_ecnt), 32'(e.ec2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    do_reset(5);
    // SEARCH through the first 15 steps, lock on the wrap, then track.
    for (int i = 0; i < 40; i++) cyc_step(1'b0, 1'b0, 4'd0, 1'b0);
    // Pause while locked at 5, then resume.
    run_until_count(4'd5);
    for (int i = 0; i < 3; i++) cyc_step(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 2; i++) cyc_step(1'b0, 1'b0, 4'd0, 1'b0);
    // Bad step pattern at count 1, then relock.
    run_until_count(4'd1);
    cyc_step(1'b0, 1'b1, 4'b0011, 1'b0);
    cyc_step(1'b0, 1'b0, 4'd0, 1'b0);
    run_until_locked();
    // Idle glitch, then clear coincident with a second error.
    cyc_step(1'b1, 1'b1, 4'b0100, 1'b0);
    run_until_locked();
    cyc_step(1'b1, 1'b1, 4'b0100, 1'b1);
    cyc_step(1'b0, 1'b0, 4'd0, 1'b0);
    // Clear with no error drops the sticky flag.
    cyc_step(1'b0, 1'b0, 4'd0, 1'b1);
    cyc_step(1'b0, 1'b0, 4'd0, 1'b0);
    // Saturate the narrow error counter.
    for (int k = 0; k < 5; k++) begin
      run_until_locked();
      cyc_step(1'b1, 1'b1, 4'(1 << (k % 4)), 1'b0);
    end
    // Random traffic with occasional forced triggers and clears.
    for (int i = 0; i < 400; i++) begin
      cyc_step(($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1,
               ($urandom_range(0, 24) == 0),
               4'($urandom),
               ($urandom_range(0, 29) == 0));
    end
    // Mid-run reset, then relock from a fresh wrap.
    run_until_locked();
    cyc_step(1'b0, 1'b0, 4'd0, 1'b0);
    do_reset(3);
    for (int i = 0; i < 40; i++) cyc_step(1'b0, 1'b0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
